// File: rtl/node_net_pkg.sv
// node_net_pkg: flit field offsets, widths, arbiter state type and VC index sizing shared by the node network blocks.
package node_net_pkg;
  localparam int FLIT_W   = 73;
  localparam int ID_W     = 8;
  localparam int DATA_W   = 32;
  localparam int CREDIT_W = 3;
  localparam int VALID    = 72;
  localparam int TAIL     = 71;
  localparam int DST_HI   = 70;
  localparam int DST_LO   = 63;
  localparam int VC_HI    = 62;
  localparam int SRC_HI   = 39;
  localparam int SRC_LO   = 32;
  localparam int DATA_HI  = 31;
  localparam int DATA_LO  = 0;
  localparam int ENTRY_W  = 1 + ID_W + DATA_W;
  typedef enum logic {ARB_IDLE, ARB_PRESENT} arb_state_t;
  function automatic int vc_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rx_vc_fifo.sv
// rx_vc_fifo: per-VC synchronous FIFO exposing head, next-after-head and occupancy for same-cycle re-arbitration.
module rx_vc_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 41
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_rd,
  output logic [W-1:0]               o_head,
  output logic [W-1:0]               o_next,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  assign o_count = r_wp - r_rp;
  assign o_full  = o_count == (AW+1)'(DEPTH);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign o_next  = r_mem[r_rp[AW-1:0] + AW'(1)];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_wr && !o_full) begin
        r_mem[r_wp[AW-1:0]] <= i_wdata;
        r_wp <= r_wp + (AW+1)'(1);
      end
      if (i_rd && o_count != '0) r_rp <= r_rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/node_rx_ejector.sv
// node_rx_ejector: buffers router flits per VC, presents them to the PE round-robin and returns freed slots as credits.
// Define RX_EJECT_STATS_EN to add saturating accepted/dropped flit counters.
module node_rx_ejector import node_net_pkg::*; #(
  parameter int NUM_VCS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int VC_BITS = vc_bits(NUM_VCS)
) (
  input  logic                N_clk,
  input  logic                N_rst,
  input  logic [ID_W-1:0]     Node_id,
  input  logic [FLIT_W-1:0]   Node_i_flit,
  output logic                Node_o_credit_valid,
  output logic [CREDIT_W-1:0] Node_o_credit,
  output logic                Rx_o_valid,
  input  logic                Rx_i_ready,
  output logic [DATA_W-1:0]   Rx_o_data,
  output logic [ID_W-1:0]     Rx_o_src,
  output logic [VC_BITS-1:0]  Rx_o_vc,
  output logic                Rx_o_tail,
`ifdef RX_EJECT_STATS_EN
  output logic [15:0]         Rx_o_stat_rx,
  output logic [15:0]         Rx_o_stat_drop,
`endif
  output logic [1:0]          Rx_o_err
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  arb_state_t r_state;
  logic [VC_BITS-1:0] r_vc, r_cptr;
  logic [ENTRY_W-1:0] r_ent;
  logic [CNT_W-1:0] r_pend [NUM_VCS];
  logic [1:0] r_err;
  logic [ENTRY_W-1:0] w_in;
  logic [ENTRY_W-1:0] w_nh [NUM_VCS];
  logic [ENTRY_W-1:0] w_head [NUM_VCS];
  logic [ENTRY_W-1:0] w_nxt [NUM_VCS];
  logic [CNT_W-1:0] w_cnt [NUM_VCS];
  logic [NUM_VCS-1:0] w_full, w_wr, w_mis, w_pop, w_avail, w_dec;
  logic [VC_BITS-1:0] w_vc, w_gnt, w_csel, w_ai, w_ci;
  logic w_fv, w_hit, w_free, w_gnt_ok, w_ovf;
  assign w_fv   = Node_i_flit[VALID];
  assign w_hit  = Node_i_flit[DST_HI:DST_LO] == Node_id;
  assign w_vc   = Node_i_flit[VC_HI -: VC_BITS];
  assign w_in   = {Node_i_flit[TAIL], Node_i_flit[SRC_HI:SRC_LO], Node_i_flit[DATA_HI:DATA_LO]};
  assign w_free = r_state == ARB_IDLE || Rx_i_ready;
  assign w_ovf  = w_fv && w_hit && w_wr == '0;
  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    assign w_wr[g]    = w_fv && w_hit && w_vc == VC_BITS'(g) && !w_full[g];
    assign w_mis[g]   = w_fv && !w_hit && w_vc == VC_BITS'(g);
    assign w_pop[g]   = r_state == ARB_PRESENT && Rx_i_ready && r_vc == VC_BITS'(g);
    assign w_dec[g]   = Node_o_credit_valid && w_csel == VC_BITS'(g);
    // The next head may be the entry behind a popped head, or the flit being written this very edge.
    assign w_avail[g] = w_wr[g] || w_cnt[g] > CNT_W'(w_pop[g]);
    assign w_nh[g]    = w_cnt[g] > CNT_W'(w_pop[g]) ? (w_pop[g] ? w_nxt[g] : w_head[g]) : w_in;
    rx_vc_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
      .clk(N_clk),
      .rst(N_rst),
      .i_wr(w_wr[g]),
      .i_wdata(w_in),
      .i_rd(w_pop[g]),
      .o_head(w_head[g]),
      .o_next(w_nxt[g]),
      .o_count(w_cnt[g]),
      .o_full(w_full[g])
    );
    always_ff @(posedge N_clk) begin
      if (N_rst) r_pend[g] <= '0;
      else r_pend[g] <= r_pend[g] + CNT_W'(w_pop[g]) + CNT_W'(w_mis[g]) - CNT_W'(w_dec[g]);
    end
  end
  always_comb begin
    w_gnt_ok = 1'b0;
    w_gnt = r_vc;
    w_ai = '0;
    for (int k = 1; k <= NUM_VCS; k++) begin
      w_ai = VC_BITS'((int'(r_vc) + k) % NUM_VCS);
      if (!w_gnt_ok && w_avail[w_ai]) begin
        w_gnt_ok = 1'b1;
        w_gnt = w_ai;
      end
    end
  end
  always_comb begin
    Node_o_credit_valid = 1'b0;
    w_csel = r_cptr;
    w_ci = '0;
    for (int k = 1; k <= NUM_VCS; k++) begin
      w_ci = VC_BITS'((int'(r_cptr) + k) % NUM_VCS);
      if (!Node_o_credit_valid && r_pend[w_ci] != '0) begin
        Node_o_credit_valid = 1'b1;
        w_csel = w_ci;
      end
    end
  end
  always_ff @(posedge N_clk) begin
    if (N_rst) begin
      r_state <= ARB_IDLE;
      r_vc <= '0;
      r_cptr <= '0;
      r_ent <= '0;
      r_err <= '0;
    end else begin
      if (w_free) r_state <= w_gnt_ok ? ARB_PRESENT : ARB_IDLE;
      if (w_free && w_gnt_ok) begin
        r_vc <= w_gnt;
        r_ent <= w_nh[w_gnt];
      end
      if (Node_o_credit_valid) r_cptr <= w_csel;
      r_err <= r_err | {|w_mis, w_ovf};
    end
  end
  assign Node_o_credit = CREDIT_W'(w_csel);
  assign Rx_o_valid = r_state == ARB_PRESENT;
  assign {Rx_o_tail, Rx_o_src, Rx_o_data} = r_ent;
  assign Rx_o_vc = r_vc;
  assign Rx_o_err = r_err;
`ifdef RX_EJECT_STATS_EN
  logic [15:0] r_stat_rx, r_stat_drop;
  always_ff @(posedge N_clk) begin
    if (N_rst) begin
      r_stat_rx <= '0;
      r_stat_drop <= '0;
    end else begin
      if (|w_wr && r_stat_rx != 16'hFFFF) r_stat_rx <= r_stat_rx + 16'd1;
      if ((|w_mis || w_ovf) && r_stat_drop != 16'hFFFF) r_stat_drop <= r_stat_drop + 16'd1;
    end
  end
  assign Rx_o_stat_rx = r_stat_rx;
  assign Rx_o_stat_drop = r_stat_drop;
`endif
endmodule

// File: tb/tb_node_rx_ejector.sv
// tb_node_rx_ejector: directed self-checking bench for node_rx_ejector with hand-computed expectations.
module tb_node_rx_ejector;
  logic clk = 1'b0;
  logic rst, rdy, cval, valid, tail;
  logic [7:0] id, src;
  logic [72:0] flit;
  logic [2:0] credit;
  logic [31:0] data;
  logic vc;
  logic [1:0] err;
  int n_cmp = 0;
  int n_bad = 0;
  int nc;
`ifdef RX_EJECT_STATS_EN
  logic [15:0] st_rx, st_drop;
`endif
  always #5 clk = ~clk;
  node_rx_ejector dut (
    .N_clk(clk),
    .N_rst(rst),
    .Node_id(id),
    .Node_i_flit(flit),
    .Node_o_credit_valid(cval),
    .Node_o_credit(credit),
    .Rx_o_valid(valid),
    .Rx_i_ready(rdy),
    .Rx_o_data(data),
    .Rx_o_src(src),
    .Rx_o_vc(vc),
    .Rx_o_tail(tail),
`ifdef RX_EJECT_STATS_EN
    .Rx_o_stat_rx(st_rx),
    .Rx_o_stat_drop(st_drop),
`endif
    .Rx_o_err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [72:0] mk(input logic t, input logic [7:0] d, input logic v, input logic [7:0] s, input logic [31:0] x);
    logic [72:0] f;
    f = '0;
    f[72] = 1'b1;
    f[71] = t;
    f[70:63] = d;
    f[62] = v;
    f[39:32] = s;
    f[31:0] = x;
    return f;
  endfunction
  initial begin
    rst = 1'b1; rdy = 1'b0; flit = '0; id = 8'd4;
    tick; tick;
    chk("rst_valid", valid, 0); chk("rst_data", data, 0); chk("rst_src", src, 0);
    chk("rst_vc", vc, 0); chk("rst_tail", tail, 0); chk("rst_err", err, 0);
    chk("rst_cval", cval, 0); chk("rst_credit", credit, 0);
    rst = 1'b0;
    // single flit
    rdy = 1'b1; flit = mk(1'b1, 8'd4, 1'b0, 8'd7, 32'hFFFFFFFF); tick; flit = '0;
    chk("t1_valid", valid, 1); chk("t1_data", data, 32'hFFFFFFFF); chk("t1_src", src, 7);
    chk("t1_tail", tail, 1); chk("t1_vc", vc, 0); chk("t1_cval_early", cval, 0);
    tick;
    chk("t1_cval", cval, 1); chk("t1_credit", credit, 0); chk("t1_valid_off", valid, 0);
    tick;
    chk("t1_cval_off", cval, 0);
    // backpressure and overflow on vc1
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flit = mk(1'b0, 8'd4, 1'b1, 8'd1, 32'h10 + i); tick;
    end
    flit = '0;
    chk("bp_valid", valid, 1); chk("bp_data", data, 32'h10); chk("bp_vc", vc, 1);
    chk("bp_cval", cval, 0); chk("bp_err", err, 0);
    flit = mk(1'b0, 8'd4, 1'b1, 8'd1, 32'h14); tick; flit = '0;
    chk("ovf_err", err, 1); chk("ovf_data_held", data, 32'h10); chk("ovf_cval", cval, 0);
    rdy = 1'b1;
    tick; chk("drain_d1", data, 32'h11); chk("drain_cval", cval, 1); chk("drain_credit", credit, 1);
    tick; chk("drain_d2", data, 32'h12);
    tick; chk("drain_d3", data, 32'h13);
    tick; chk("drain_empty", valid, 0); chk("drain_cval_last", cval, 1);
    tick; chk("drain_cval_off", cval, 0);
    // two VCs interleaved
    nc = 0;
    for (int k = 1; k <= 8; k++) begin
      flit = mk(1'b0, 8'd4, 1'((k - 1) % 2), 8'h20, 32'(k)); tick;
      chk("rr_data", data, 32'(k)); chk("rr_vc", vc, 32'((k - 1) % 2));
      if (cval) nc++;
    end
    flit = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (cval) nc++;
    end
    chk("rr_credits", nc, 8); chk("rr_err", err, 1);
    // misroute
    flit = mk(1'b1, 8'd5, 1'b0, 8'd9, 32'hAA); tick; flit = '0;
    chk("mis_valid", valid, 0); chk("mis_err", err, 3); chk("mis_cval", cval, 1); chk("mis_credit", credit, 0);
    tick; chk("mis_cval_off", cval, 0);
    // pop on vc0 with misroute credit on vc1
    flit = mk(1'b1, 8'd4, 1'b0, 8'd1, 32'h55); tick;
    chk("pc_valid", valid, 1); chk("pc_data", data, 32'h55);
    flit = mk(1'b1, 8'd5, 1'b1, 8'd1, 32'h66); tick; flit = '0;
    chk("pc_cval1", cval, 1); chk("pc_credit1", credit, 1);
    tick; chk("pc_cval2", cval, 1); chk("pc_credit2", credit, 0);
    tick; chk("pc_cval_off", cval, 0);
    // reset with buffered flits
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flit = mk(1'b0, 8'd4, 1'b0, 8'd3, 32'h71 + i); tick;
    end
    flit = '0;
    chk("mr_valid_pre", valid, 1); chk("mr_data_pre", data, 32'h71);
    rst = 1'b1; tick;
    chk("mr_valid", valid, 0); chk("mr_data", data, 0); chk("mr_src", src, 0); chk("mr_tail", tail, 0);
    chk("mr_vc", vc, 0); chk("mr_err", err, 0); chk("mr_cval", cval, 0); chk("mr_credit", credit, 0);
`ifdef RX_EJECT_STATS_EN
    chk("mr_stat_rx", st_rx, 0); chk("mr_stat_drop", st_drop, 0);
`endif
    rst = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; chk("mr_no_stale", valid, 0);
    end
    chk("mr_no_credit", cval, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/node_rx_ejector.md
# node_rx_ejector

Receive-side ejection stage between the router's local output port and the node's PE. It accepts flits arriving on the router link and buffers them in per-VC FIFOs. Buffered payloads go to the PE over a valid/ready handshake, and each freed buffer slot is returned to the router as a credit. It is the consumer counterpart of the PE-to-router send interface inside the node.

## Interface
- NUM_VCS, 2, virtual channels (VC_BITS = max(1, clog2(NUM_VCS)))
- FIFO_DEPTH, 4, flit slots per VC (power of two, ≥2)
- N_clk  in  1  clock
- N_rst  in  1  reset; synchronous, active-high
- Node_id  in  8  local node id, sampled every cycle
- Node_i_flit  in  73  router flit: [72] valid, [71] tail, [70:63] dst, [62 -: VC_BITS] vc, [39:32] src, [31:0] data; other bits ignored
- Node_o_credit_valid  out  1  one credit returned this cycle
- Node_o_credit  out  3  VC index of returned credit, zero-extended
- Rx_o_valid  out  1  payload available to PE
- Rx_i_ready  in  1  PE accepts payload
- Rx_o_data  out  32  payload data
- Rx_o_src  out  8  source node id
- Rx_o_vc  out  VC_BITS  VC of payload
- Rx_o_tail  out  1  payload was a tail flit
- Rx_o_err  out  2  sticky: [0] overflow, [1] misroute

## Operation
- Ingress: when flit[72]=1, select the FIFO by its vc field.
  - If dst == Node_id and the FIFO is not full: write {tail, src, data}.
  - If dst != Node_id: drop the flit, set err[1], and queue a credit for that VC.
  - If the FIFO is full: drop the flit, set err[0], and queue no credit.
- Egress arbiter, two states:
  - IDLE: round-robin over non-empty VCs, starting after the last granted VC. The winning VC is locked and the arbiter enters PRESENT.
  - PRESENT: Rx_o_valid=1 and the fields show that FIFO's head. The outputs must stay stable until Rx_i_ready=1.
  - On valid&ready: pop the head, queue a credit, and return to IDLE. If another VC is non-empty, arbitrate directly to it in the same cycle (back-to-back transfer).
- Credit return:
  - Per-VC pending-credit counter, width clog2(FIFO_DEPTH)+1.
  - At most one credit is issued per cycle, chosen round-robin over non-zero counters.
  - Issuing a credit decrements its counter. Increment and decrement on the same counter in the same cycle leave it unchanged.
- A pop and a write on the same VC in the same cycle are both performed. A full FIFO that pops this cycle still refuses this cycle's write, because fullness is evaluated on pre-edge state.
- Err bits clear only on reset.

## Timing
- Reset values:
  - Outputs: Node_o_credit_valid=0, Node_o_credit=0, Rx_o_valid=0, Rx_o_data=0, Rx_o_src=0, Rx_o_vc=0, Rx_o_tail=0, Rx_o_err=0.
  - Internal: FIFOs empty, pending counters 0, RR pointers 0, arbiter IDLE.
- Reset mid-operation discards all buffered flits and pending credits. The router is reset on the same N_rst, so the credit loop is re-initialised consistently.
- Ingress-to-egress: a flit written at the edge ending cycle t produces Rx_o_valid=1 in cycle t+1, if it is granted.
- Pop-to-credit: a handshake in cycle t gives Node_o_credit_valid=1 no earlier than cycle t+1.
- Egress sustains one payload per cycle while Rx_i_ready=1.
- The credit port returns at most one credit per cycle. Backlogged credits drain in successive cycles.
- Rx_o_* fields are registered. No combinational path from Rx_i_ready or Node_i_flit to any output.

## Configuration
- RX_EJECT_STATS_EN defined:
  - Adds output ports Rx_o_stat_rx (16 bits, flits accepted into a FIFO) and Rx_o_stat_drop (16 bits, flits dropped).
  - Both counters saturate at 16'hFFFF and reset to 0.
- RX_EJECT_STATS_EN undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- Shared package node_net_pkg holds:
  - flit field offsets (VALID=72, TAIL=71, DST_HI/LO=70/63, VC_HI=62, SRC_HI/LO=39/32, DATA_HI/LO=31/0);
  - FLIT_W=73, ID_W=8, DATA_W=32, CREDIT_W=3;
  - a clog2-based VC_BITS function.
- One sub-module, rx_vc_fifo: synchronous FIFO, 41-bit entries {tail, src, data}, with full/empty flags, instantiated NUM_VCS times.
- The arbiter and credit counters live in the top level.

## Test plan
- Single flit, reset release, Node_id=4: flit valid=1, tail=1, dst=4, vc=0, src=7, data=32'hFFFFFFFF with Rx_i_ready=1. Expect Rx_o_valid=1 next cycle with data FFFFFFFF, src 7, tail 1, then credit_valid=1, Node_o_credit=0 one cycle after the handshake.
- Backpressure: 4 flits on vc1 with Rx_i_ready=0. Expect outputs held stable on the first flit, no credits, err=0. A 5th flit sets err[0] and is not delivered.
- Two VCs, Rx_i_ready=1 throughout: alternating vc0/vc1 data 1..8. Expect delivery interleaved by round-robin, each VC in order, and 8 credits over consecutive cycles.
- Misroute: dst=5 with Node_id=4. Expect no Rx_o_valid, err[1]=1, and one credit for that VC.
- Simultaneous pop and drop-credit on different VCs: expect two credits on consecutive cycles, none lost.
- Reset asserted with 3 flits buffered: expect all outputs 0 the next cycle and no stale flit delivered afterwards. With RX_EJECT_STATS_EN, the counters read 0.
